// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle of uart_cmd_ctrl: UART byte streams, memory request port and status.
// master = the controller, slave = the UART pair / memory environment.
interface uart_cmd_ctrl_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [7:0]        rx_data;
   logic              po_flag;
   logic [7:0]        tx_data;
   logic              tx_trig;
   logic              tx_busy;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   logic              ovr;
   logic              busy;

   modport master (
      input  rx_data, po_flag, tx_busy, mem_ack, mem_rdata,
      output tx_data, tx_trig, mem_req, mem_we, mem_addr, mem_wdata, ovr, busy
   );

   modport slave (
      output rx_data, po_flag, tx_busy, mem_ack, mem_rdata,
      input  tx_data, tx_trig, mem_req, mem_we, mem_addr, mem_wdata, ovr, busy
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: assembles OP/ADDR_HI/ADDR_LO/DATA frames, issues one memory
// access per frame and answers with one byte. Define CMD_CHECKSUM_EN for a trailing XOR byte.
module uart_cmd_ctrl #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 50000,
   parameter logic [7:0]  OP_WR   = 8'h55,
   parameter logic [7:0]  OP_RD   = 8'hAA,
   parameter logic [7:0]  RSP_ACK = 8'h06,
   parameter logic [7:0]  RSP_NAK = 8'h15
) (
   input logic             i_clk,
   input logic             i_rstn,
   uart_cmd_ctrl_if.master io_bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_OP,
      S_AH,
      S_AL,
      S_D,
`ifdef CMD_CHECKSUM_EN
      S_CS,
`endif
      S_MEM,
      S_TX,
      S_TXW
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_op, r_ah, r_al, r_d, r_tx_data;
   logic [7:0]       w_op_nxt, w_ah_nxt, w_al_nxt, w_d_nxt, w_tx_nxt;
   logic [CNT_W-1:0] r_gap, w_gap_nxt;
   logic             r_guard, w_guard_nxt;
   logic             w_rcv, w_trig, w_ovr;
   logic             w_po;

   assign w_po = io_bus.po_flag;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_OP;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_op      <= '0;
         r_ah      <= '0;
         r_al      <= '0;
         r_d       <= '0;
         r_tx_data <= '0;
         r_gap     <= '0;
         r_guard   <= 1'b0;
      end else begin
         r_op      <= w_op_nxt;
         r_ah      <= w_ah_nxt;
         r_al      <= w_al_nxt;
         r_d       <= w_d_nxt;
         r_tx_data <= w_tx_nxt;
         r_gap     <= w_gap_nxt;
         r_guard   <= w_guard_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_ah_nxt    = r_ah;
      w_al_nxt    = r_al;
      w_d_nxt     = r_d;
      w_tx_nxt    = r_tx_data;
      w_gap_nxt   = r_gap;
      w_guard_nxt = r_guard;
      w_trig      = 1'b0;
      w_ovr       = 1'b0;

      w_rcv = (r_state == S_AH) || (r_state == S_AL) || (r_state == S_D);
`ifdef CMD_CHECKSUM_EN
      w_rcv = w_rcv || (r_state == S_CS);
`endif

      // Inter-byte gap watchdog; a received byte always wins over an expiring count.
      if (w_rcv) begin
         if (w_po) begin
            w_gap_nxt = '0;
         end else if (r_gap == GAP_LAST) begin
            w_gap_nxt   = '0;
            w_state_nxt = S_OP;
         end else begin
            w_gap_nxt = r_gap + CNT_W'(1);
         end
      end

      unique case (r_state)
         S_OP: begin
            if (w_po) begin
               if (io_bus.rx_data == OP_WR || io_bus.rx_data == OP_RD) begin
                  w_op_nxt    = io_bus.rx_data;
                  w_gap_nxt   = '0;
                  w_state_nxt = S_AH;
               end else begin
                  w_tx_nxt    = RSP_NAK;
                  w_state_nxt = S_TX;
               end
            end
         end
         S_AH: begin
            if (w_po) begin
               w_ah_nxt    = io_bus.rx_data;
               w_state_nxt = S_AL;
            end
         end
         S_AL: begin
            if (w_po) begin
               w_al_nxt    = io_bus.rx_data;
               w_state_nxt = S_D;
            end
         end
         S_D: begin
            if (w_po) begin
               w_d_nxt = io_bus.rx_data;
`ifdef CMD_CHECKSUM_EN
               w_state_nxt = S_CS;
`else
               w_state_nxt = S_MEM;
`endif
            end
         end
`ifdef CMD_CHECKSUM_EN
         S_CS: begin
            if (w_po) begin
               if ((r_op ^ r_ah ^ r_al ^ r_d ^ io_bus.rx_data) == 8'h00) begin
                  w_state_nxt = S_MEM;
               end else begin
                  w_tx_nxt    = RSP_NAK;
                  w_state_nxt = S_TX;
               end
            end
         end
`endif
         S_MEM: begin
            w_ovr = w_po;
            if (io_bus.mem_ack) begin
               w_tx_nxt    = (r_op == OP_WR) ? RSP_ACK : io_bus.mem_rdata;
               w_state_nxt = S_TX;
            end
         end
         S_TX: begin
            w_ovr = w_po;
            if (!io_bus.tx_busy) begin
               w_trig      = 1'b1;
               w_guard_nxt = 1'b1;
               w_state_nxt = S_TXW;
            end
         end
         S_TXW: begin
            w_ovr = w_po;
            // First cycle skipped: tx_busy only rises the cycle after tx_trig.
            if (r_guard) begin
               w_guard_nxt = 1'b0;
            end else if (!io_bus.tx_busy) begin
               w_state_nxt = S_OP;
            end
         end
         default: w_state_nxt = S_OP;
      endcase
   end

   assign io_bus.tx_data   = r_tx_data;
   assign io_bus.tx_trig   = w_trig;
   assign io_bus.mem_req   = (r_state == S_MEM);
   assign io_bus.mem_we    = (r_op == OP_WR);
   assign io_bus.mem_addr  = ADDR_W'({r_ah, r_al});
   assign io_bus.mem_wdata = r_d;
   assign io_bus.ovr       = w_ovr;
   assign io_bus.busy      = (r_state != S_OP);
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART pair (uart_rx / uart_tx) and a single-port memory request interface on the SDRAM side.
- Assembles fixed-length command frames from received bytes and issues one memory read or write per frame.
- Returns a one-byte response through uart_tx with a single-pulse trigger/busy handshake.
- Serves as the host debug/load path into SDRAM.

Parameters:
ADDR_W, 16, memory address width; the frame carries exactly 16 address bits, zero-extended if ADDR_W > 16.
TIMEOUT, 50000, max clk cycles allowed between two bytes of one frame before the partial frame is discarded.
OP_WR, 8'h55, write opcode.
OP_RD, 8'hAA, read opcode.
RSP_ACK, 8'h06, write-done response byte.
RSP_NAK, 8'h15, error response byte.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
rx_data  input  8  byte from uart_rx, valid when po_flag=1
po_flag  input  1  one-cycle pulse, received byte valid
tx_data  output  8  byte to uart_tx, valid in tx_trig cycle
tx_trig  output  1  one-cycle start pulse to uart_tx
tx_busy  input  1  uart_tx busy; rises the cycle after tx_trig
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1=write, 0=read; stable while mem_req
mem_addr  output  ADDR_W  request address
mem_wdata  output  8  write data
mem_ack  input  1  one-cycle completion; mem_rdata valid in the same cycle
mem_rdata  input  8  read data
ovr  output  1  one-cycle pulse: byte dropped because the controller was busy
busy  output  1  high in any state other than S_OP

Behaviour:
- Reset (rstn=0, async): state S_OP. All outputs 0: tx_data, tx_trig, mem_req, mem_we, mem_addr, mem_wdata, ovr, busy. Gap counter and byte registers cleared.
- Frame format: OP, ADDR_HI, ADDR_LO, DATA. DATA is sent for reads too and ignored.
- States: S_OP, S_AH, S_AL, S_D, [S_CS], S_MEM, S_TX, S_TXW.
- Receive states advance one state per po_flag and latch rx_data into the matching register.
- In S_OP, opcode is checked immediately. Not OP_WR/OP_RD → byte dropped, next state S_TX with tx_data=RSP_NAK.
- Gap counter: cleared on each po_flag, counts in S_AH..S_CS. Reaching TIMEOUT-1 → return to S_OP; no response, no memory access.
- Last frame byte accepted in cycle N → S_MEM entered at N+1 with mem_req=1 and mem_we/mem_addr/mem_wdata driven from the latched frame.
- mem_req stays high until the mem_ack cycle and is low from the next cycle. mem_ack outside S_MEM is ignored. No memory timeout.
- mem_ack cycle M:
  - Write: tx_data=RSP_ACK.
  - Read: tx_data=mem_rdata, latched at M.
  - Both: enter S_TX at M+1.
- S_TX: if tx_busy=0, assert tx_trig for exactly 1 cycle and go to S_TXW. Otherwise wait in S_TX.
- S_TXW: ignore tx_busy in the first cycle (guard), then wait for tx_busy=0, then go to S_OP. tx_data holds its value until S_OP.
- po_flag in S_MEM/S_TX/S_TXW: byte dropped, ovr pulses the same cycle, state unchanged.
- po_flag coincident with mem_ack: byte dropped (ovr=1) and mem_ack still processed.
- Reset mid-frame or mid-request: immediate abort to reset values. A pending mem_req drops asynchronously; the memory side must tolerate this.

Optional Feature:
CMD_CHECKSUM_EN defined:
- A fifth frame byte CS follows DATA; state S_CS is present.
- Frame is valid only if OP^ADDR_HI^ADDR_LO^DATA^CS == 8'h00.
- Mismatch → no memory access, RSP_NAK sent via S_TX.
- The gap timeout also applies between DATA and CS.
CMD_CHECKSUM_EN undefined:
- 4-byte frames; S_CS is absent and no integrity check is done.

Test Plan:
1. Write: bytes 55,12,34,A5 → mem_req with mem_we=1, mem_addr=16'h1234, mem_wdata=A5 one cycle after the 4th po_flag; ack after 3 cycles → exactly one tx_trig with tx_data=06.
2. Read: bytes AA,12,34,00; mem_ack with mem_rdata=3C → mem_we=0, addr 1234, one tx_trig with tx_data=3C; the received UART byte equals 3C.
3. Bad opcode 7E → no mem_req; one tx_trig with tx_data=15; next frame 55,00,01,11 is accepted normally.
4. Timeout: bytes 55,12, then silence for TIMEOUT cycles, then AA,00,02,00 → no write ever issued; read of addr 0002 issued.
5. Overrun + tx_busy: hold mem_ack off and inject a byte → ovr pulses once, state unchanged. Hold tx_busy=1 → tx_trig delayed until busy falls, still a single pulse.
6. (CMD_CHECKSUM_EN) 55,12,34,A5,D6 → write + 06. Same frame with CS=00 → no mem_req, response 15.
